// File: rtl/adder_arbiter.sv
// adder_arbiter: two-requester round-robin front end sharing one ripple adder, with a one-deep result register

// adder: ripple add/subtract; sel[3] selects subtract, any other set bit marks an unsupported op
module adder #(
   parameter int W = 32
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic [3:0]   i_sel,
   output logic [W-1:0] o_sum,
   output logic         o_err
);
   logic [W-1:0] w_b;
   logic [W-1:0] w_c;
   assign w_b    = i_b ^ {W{i_sel[3]}};
   assign w_c[0] = i_sel[3];
   assign o_err  = |i_sel[2:0];
   genvar i;
   for (i = 0; i < W; i++) begin : g_fa
      assign o_sum[i] = i_a[i] ^ w_b[i] ^ w_c[i];
      if (i < W - 1) begin : g_c
         assign w_c[i+1] = (i_a[i] & w_b[i]) | (w_c[i] & (i_a[i] ^ w_b[i]));
      end
   end
endmodule

module adder_arbiter #(
   parameter int OPERAND_LENGTH = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req0_valid,
   output logic                      req0_ready,
   input  logic [OPERAND_LENGTH-1:0] req0_opd1,
   input  logic [OPERAND_LENGTH-1:0] req0_opd2,
   input  logic [3:0]                req0_op,
   input  logic                      req1_valid,
   output logic                      req1_ready,
   input  logic [OPERAND_LENGTH-1:0] req1_opd1,
   input  logic [OPERAND_LENGTH-1:0] req1_opd2,
   input  logic [3:0]                req1_op,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [OPERAND_LENGTH-1:0] rsp_result,
   output logic                      rsp_id,
   output logic                      rsp_err
);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t                    r_state;
   state_t                    w_next;
   logic                      r_prio;
   logic                      r_id;
   logic                      r_err;
   logic [OPERAND_LENGTH-1:0] r_result;
   logic                      w_can;
   logic                      w_gnt0;
   logic                      w_gnt1;
   logic                      w_acc;
   logic [OPERAND_LENGTH-1:0] w_sum;
   logic                      w_err;
   // rst_n gating keeps both readys low while reset is held
   assign w_can  = rst_n & ((r_state == EMPTY) | rsp_ready);
   assign w_gnt0 = w_can & req0_valid & (~req1_valid | ~r_prio);
   assign w_gnt1 = w_can & req1_valid & (~req0_valid | r_prio);
   assign w_acc  = w_gnt0 | w_gnt1;
   assign req0_ready = w_gnt0;
   assign req1_ready = w_gnt1;
   assign rsp_valid  = (r_state == FULL);
   assign rsp_result = r_result;
   assign rsp_id     = r_id;
   assign rsp_err    = r_err;
   adder #(.W(OPERAND_LENGTH)) u_adder (
      .i_a   (w_gnt1 ? req1_opd1 : req0_opd1),
      .i_b   (w_gnt1 ? req1_opd2 : req0_opd2),
      .i_sel (w_gnt1 ? req1_op : req0_op),
      .o_sum (w_sum),
      .o_err (w_err)
   );
   // next state: acceptance fills, a drain without acceptance empties
   always_comb begin
      w_next = w_acc ? FULL : (rsp_ready ? EMPTY : r_state);
   end
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= EMPTY;
      else        r_state <= w_next;
   end
   // result capture and round-robin pointer, both only on acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result <= '0;
         r_id     <= 1'b0;
         r_err    <= 1'b0;
         r_prio   <= 1'b0;
      end else if (w_acc) begin
         r_result <= w_sum;
         r_id     <= w_gnt1;
         r_err    <= w_err;
         r_prio   <= w_gnt0;
      end
   end
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed checks of arbitration, arithmetic, backpressure and reset
module tb_adder_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_opd1 = '0, req0_opd2 = '0, req1_opd1 = '0, req1_opd2 = '0;
   logic [3:0]  req0_op = '0, req1_op = '0;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_err;
   logic [31:0] rsp_result;
   int          checks = 0;
   int          errors = 0;

   adder_arbiter #(.OPERAND_LENGTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_opd1(req0_opd1), .req0_opd2(req0_opd2), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_opd1(req1_opd1), .req1_opd2(req1_opd2), .req1_op(req1_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_id(rsp_id), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rsp(input string tag, input logic v, input logic [31:0] r, input logic id, input logic e);
      chk({tag, "_valid"}, 32'(rsp_valid), 32'(v));
      chk({tag, "_result"}, rsp_result, r);
      chk({tag, "_id"}, 32'(rsp_id), 32'(id));
      chk({tag, "_err"}, 32'(rsp_err), 32'(e));
   endtask

   task automatic rdy(input string tag, input logic r0, input logic r1);
      chk({tag, "_ready0"}, 32'(req0_ready), 32'(r0));
      chk({tag, "_ready1"}, 32'(req1_ready), 32'(r1));
   endtask

   initial begin
      // reset: outputs cleared, no ready even with a valid request
      req0_valid = 1'b1;
      rsp_ready  = 1'b1;
      #12;
      rsp("reset", 1'b0, 32'd0, 1'b0, 1'b0);
      rdy("reset", 1'b0, 1'b0);
      // single add, accepted at the first edge after release
      req0_opd1 = 32'd5; req0_opd2 = 32'd7; req0_op = 4'b0000;
      rst_n = 1'b1;
      #1;
      rdy("add", 1'b1, 1'b0);
      tick();
      rsp("add", 1'b1, 32'd12, 1'b0, 1'b0);
      // subtract with wrap from requester 1
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_opd1 = 32'd3; req1_opd2 = 32'd5; req1_op = 4'b1000;
      #1;
      rdy("sub", 1'b0, 1'b1);
      tick();
      rsp("sub", 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
      // contention: alternating grants starting with requester 0
      req0_valid = 1'b1; req0_opd1 = 32'd10; req0_opd2 = 32'd1; req0_op = 4'b0000;
      req1_opd1 = 32'd20; req1_opd2 = 32'd2; req1_op = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         #1;
         rdy($sformatf("rr%0d", k), k % 2 == 0, k % 2 == 1);
         tick();
         rsp($sformatf("rr%0d", k), 1'b1, (k % 2 == 0) ? 32'd11 : 32'd22, k % 2 == 1, 1'b0);
      end
      // backpressure: held result stays put, nobody is granted
      rsp_ready = 1'b0;
      req0_opd1 = 32'd100; req1_opd1 = 32'd200;
      #1;
      rdy("bp", 1'b0, 1'b0);
      tick();
      rsp("bp", 1'b1, 32'd22, 1'b1, 1'b0);
      tick();
      rsp("bp2", 1'b1, 32'd22, 1'b1, 1'b0);
      rsp_ready = 1'b1;
      #1;
      rdy("bp_rel", 1'b1, 1'b0);
      tick();
      rsp("bp_rel", 1'b1, 32'd101, 1'b0, 1'b0);
      // unsupported ops: computed from bit 3 and flagged
      req1_valid = 1'b0;
      req0_opd1 = 32'd1; req0_opd2 = 32'd1; req0_op = 4'b0001;
      #1;
      rdy("err_add", 1'b1, 1'b0);
      tick();
      rsp("err_add", 1'b1, 32'd2, 1'b0, 1'b1);
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_opd1 = 32'd5; req1_opd2 = 32'd3; req1_op = 4'b1001;
      tick();
      rsp("err_sub", 1'b1, 32'd2, 1'b1, 1'b1);
      // drain
      req1_valid = 1'b0;
      tick();
      chk("drain_valid", 32'(rsp_valid), 32'd0);
      // fill from requester 0 so the pointer favours requester 1, then reset mid-hold
      req0_valid = 1'b1; req0_opd1 = 32'd7; req0_opd2 = 32'd1; req0_op = 4'b0000;
      tick();
      req0_valid = 1'b0;
      rsp_ready  = 1'b0;
      rsp("hold", 1'b1, 32'd8, 1'b0, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      rsp("midrst", 1'b0, 32'd0, 1'b0, 1'b0);
      #1;
      rst_n = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
      req0_opd1 = 32'd4; req0_opd2 = 32'd4; req1_opd1 = 32'd9; req1_opd2 = 32'd9;
      #1;
      rdy("postrst", 1'b1, 1'b0);
      tick();
      rsp("postrst", 1'b1, 32'd8, 1'b0, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
